pipe_stage_regs: RTL and testbench

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

---
 rtl/pipe_stage_regs_pkg.sv | 54 +++++
 rtl/pipe_stage_regs_stage_reg.sv | 29 ++
 rtl/pipe_stage_regs.sv | 75 +++++++
 tb/tb_pipe_stage_regs.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the D/E/M/W pipeline stage registers: bubble word,
// instruction field ranges, watchdog limit and the per-stage register record.
package pipe_stage_regs_pkg;

    // All-zero word decodes as sll $0,$0,0, so hazard logic sees no writer.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Instruction field ranges (MIPS R-format layout).
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;

    // Longest legal run of consecutive stalls (lw in E, then branch/jr in D).
    localparam logic [1:0] MAX_STALL_RUN = 2'd2;
    localparam logic [1:0] RUN_LEN_SAT   = 2'd3;

    // One pipeline stage: instruction, its PC, and whether it is real work.
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        valid;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{ir: NOP_WORD, pc: 32'h0, valid: 1'b0};

    // Field extractors for hazard-decode logic that consumes these stages.
    function automatic logic [5:0] op_of(input logic [31:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] ir);
        return ir[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] ir);
        return ir[RT_HI:RT_LO];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic [5:0] func_of(input logic [31:0] ir);
        return ir[FUNC_HI:FUNC_LO];
    endfunction

endpackage

// File: rtl/pipe_stage_regs_stage_reg.sv
// One pipeline stage register (ir + pc + valid) with hold and bubble controls.
// hold has priority: a held stage keeps its contents even if bubble is set.
module stage_reg
    import pipe_stage_regs_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   bubble,
    input  stage_t d_in,
    output stage_t q
);

    // Stage register: clear on reset, otherwise hold, insert bubble, or load.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every stage
        // samples the previous stage's pre-edge value (a true shift register).
        if (!rst_n) begin
            q <= STAGE_EMPTY;
        end else if (!hold) begin
            if (bubble) begin
                q <= STAGE_EMPTY;
            end else begin
                q <= d_in;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// Pipeline stage registers D/E/M/W with stall handling, a stall-run watchdog
// and an optional stall-cycle counter enabled by `define PIPE_STALL_CNT_EN.
// A stall holds D, injects a bubble into E, and lets M and W keep advancing.
module pipe_stage_regs
    import pipe_stage_regs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir_f,
    input  logic [31:0] pc_f,
    input  logic        stall,
    output logic [31:0] ir_d,
    output logic [31:0] pc_d,
    output logic [31:0] ir_e,
    output logic [31:0] pc_e,
    output logic [31:0] ir_m,
    output logic [31:0] pc_m,
    output logic [31:0] ir_w,
    output logic [31:0] pc_w,
    output logic        valid_d,
    output logic        valid_e,
    output logic        valid_m,
    output logic        valid_w,
    output logic        pc_en,
    output logic        stall_err,
    output logic [31:0] stall_cnt
);

    stage_t s_f, s_d, s_e, s_m, s_w;
    logic [1:0] run_len;

    assign s_f   = '{ir: ir_f, pc: pc_f, valid: 1'b1};
    assign pc_en = ~stall;

    stage_reg u_d (.clk(clk), .rst_n(rst_n), .hold(stall), .bubble(1'b0),  .d_in(s_f), .q(s_d));
    stage_reg u_e (.clk(clk), .rst_n(rst_n), .hold(1'b0),  .bubble(stall), .d_in(s_d), .q(s_e));
    stage_reg u_m (.clk(clk), .rst_n(rst_n), .hold(1'b0),  .bubble(1'b0),  .d_in(s_e), .q(s_m));
    stage_reg u_w (.clk(clk), .rst_n(rst_n), .hold(1'b0),  .bubble(1'b0),  .d_in(s_m), .q(s_w));

    assign ir_d = s_d.ir;  assign pc_d = s_d.pc;  assign valid_d = s_d.valid;
    assign ir_e = s_e.ir;  assign pc_e = s_e.pc;  assign valid_e = s_e.valid;
    assign ir_m = s_m.ir;  assign pc_m = s_m.pc;  assign valid_m = s_m.valid;
    assign ir_w = s_w.ir;  assign pc_w = s_w.pc;  assign valid_w = s_w.valid;

    // Watchdog: count consecutive stalled edges; one beyond the legal run is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len   <= 2'd0;
            stall_err <= 1'b0;
        end else if (stall) begin
            if (run_len >= MAX_STALL_RUN) begin
                stall_err <= 1'b1;
            end
            if (run_len != RUN_LEN_SAT) begin
                run_len <= run_len + 2'd1;
            end
        end else begin
            run_len <= 2'd0;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Stall-cycle counter: free-running over stalled edges, wraps, reset-only clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Scoreboard bench for pipe_stage_regs: the driver predicts, per instruction
// entering D, the edge at which it must reach W and queues it; a monitor
// compares W, D, E, watchdog and counter state after every rising edge.
module tb_pipe_stage_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] ir_f = 32'h0, pc_f = 32'h0;
    logic [31:0] ir_d, pc_d, ir_e, pc_e, ir_m, pc_m, ir_w, pc_w;
    logic        valid_d, valid_e, valid_m, valid_w;
    logic        pc_en, stall_err;
    logic [31:0] stall_cnt;

    pipe_stage_regs dut (
        .clk(clk), .rst_n(rst_n), .ir_f(ir_f), .pc_f(pc_f), .stall(stall),
        .ir_d(ir_d), .pc_d(pc_d), .ir_e(ir_e), .pc_e(pc_e),
        .ir_m(ir_m), .pc_m(pc_m), .ir_w(ir_w), .pc_w(pc_w),
        .valid_d(valid_d), .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .pc_en(pc_en), .stall_err(stall_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        int          arrive;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_no = 0;

    // Reference model state (what the pipeline must hold after the next edge).
    logic [31:0] m_d_ir = 0, m_d_pc = 0, m_e_ir = 0, m_e_pc = 0;
    logic        m_d_valid = 0, m_e_valid = 0, m_err = 0;
    int          m_consec = 0;
    logic [31:0] m_cnt = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, edge_no);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_irpc_de"}, {ir_d, pc_d, ir_e}, 96'h0);
        check({tag, "_irpc_emw"}, {pc_e, ir_m, pc_m}, 96'h0);
        check({tag, "_irpc_w"}, {32'h0, ir_w, pc_w}, 96'h0);
        check({tag, "_valid_err_cnt"}, {58'h0, valid_d, valid_e, valid_m, valid_w, stall_err, stall_cnt},
              96'h0);
    endtask

    // Apply one cycle of stimulus at the falling edge and advance the model.
    task automatic drive(input logic s, input logic [31:0] ir, input logic [31:0] pc);
        @(negedge clk);
        rst_n = 1'b1;
        stall = s;
        ir_f  = ir;
        pc_f  = pc;
        #1;
        check("pc_en", {95'h0, pc_en}, {95'h0, ~s});
        if (!s) begin
            // Leaving D on this edge: E, M, W follow on the next three edges.
            if (m_d_valid) exp_q.push_back('{ir: m_d_ir, pc: m_d_pc, arrive: edge_no + 3});
            m_e_ir = m_d_ir; m_e_pc = m_d_pc; m_e_valid = m_d_valid;
            m_d_ir = ir; m_d_pc = pc; m_d_valid = 1'b1;
            m_consec = 0;
        end else begin
            m_e_ir = 0; m_e_pc = 0; m_e_valid = 0;
            m_consec++;
            m_cnt++;
            if (m_consec > 2) m_err = 1'b1;
        end
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic do_reset(input logic s);
        @(negedge clk);
        stall = s;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_d_ir = 0; m_d_pc = 0; m_d_valid = 0;
        m_e_ir = 0; m_e_pc = 0; m_e_valid = 0;
        m_consec = 0; m_err = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    // Monitor: after each rising edge, retire or reject whatever W presents.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (exp_q.size() > 0 && exp_q[0].arrive == edge_no) begin
                exp_t e;
                e = exp_q.pop_front();
                check("w_out", {31'h0, valid_w, ir_w, pc_w}, {31'h0, 1'b1, e.ir, e.pc});
            end else begin
                check("w_bubble", {31'h0, valid_w, ir_w, pc_w}, 96'h0);
            end
            check("d_stage", {31'h0, valid_d, ir_d, pc_d}, {31'h0, m_d_valid, m_d_ir, m_d_pc});
            check("e_stage", {31'h0, valid_e, ir_e, pc_e}, {31'h0, m_e_valid, m_e_ir, m_e_pc});
            check("stall_err", {95'h0, stall_err}, {95'h0, m_err});
`ifdef PIPE_STALL_CNT_EN
            check("stall_cnt", {64'h0, stall_cnt}, {64'h0, m_cnt});
`else
            check("stall_cnt", {64'h0, stall_cnt}, 96'h0);
`endif
        end
    end

    initial begin
        #3;
        check_all_zero("power_on_reset");

        // lw travels to W in 4 edges, beq then stalls in D for 2 legal cycles.
        drive(1'b0, 32'h8C08_0000, 32'h0000_3000);
        drive(1'b0, 32'h1008_0002, 32'h0000_3004);
        drive(1'b1, 32'hDEAD_BEEF, 32'h0000_3008);
        drive(1'b1, 32'hCAFE_F00D, 32'h0000_300C);
        drive(1'b0, 32'h0000_0020, 32'h0000_3008);
        drive(1'b0, 32'h0000_0021, 32'h0000_300C);
        drive(1'b0, 32'h0000_0022, 32'h0000_3010);

        // Three consecutive stalls trip the sticky watchdog.
        drive(1'b1, 32'h1111_1111, 32'h0000_4000);
        drive(1'b1, 32'h2222_2222, 32'h0000_4004);
        drive(1'b1, 32'h3333_3333, 32'h0000_4008);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0100_0000 + i, 32'h0000_5000 + 4 * i);

        // Reset mid-stall with beq held in D; next edge loads ir_f normally.
        drive(1'b0, 32'h1008_0002, 32'h0000_6000);
        drive(1'b1, 32'h0000_0000, 32'h0000_6004);
        do_reset(1'b1);
        drive(1'b0, 32'h2008_0001, 32'h0000_7000);

        // Five stalled edges interleaved with three unstalled ones.
        do_reset(1'b0);
        drive(1'b1, 32'hA0, 32'h0);
        drive(1'b0, 32'hA1, 32'h4);
        drive(1'b1, 32'hA2, 32'h8);
        drive(1'b0, 32'hA3, 32'hC);
        drive(1'b1, 32'hA4, 32'h10);
        drive(1'b1, 32'hA5, 32'h14);
        drive(1'b0, 32'hA6, 32'h18);
        drive(1'b1, 32'hA7, 32'h1C);
        @(posedge clk);
        #2;
`ifdef PIPE_STALL_CNT_EN
        check("stall_cnt_five", {64'h0, stall_cnt}, {64'h0, 32'd5});
`else
        check("stall_cnt_tied", {64'h0, stall_cnt}, 96'h0);
`endif

        // Randomised traffic with occasional stall runs and resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) do_reset(r[0]);
            else drive(r < 35, $urandom, $urandom);
        end

        for (int i = 0; i < 6; i++) drive(1'b0, $urandom, $urandom);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
